// File: rtl/serial_right_shifter_pkg.sv
// Shared encodings and helpers for the serial right shifter.
// Package name is shifter_pkg so existing imports keep working.
package shifter_pkg;

    localparam logic [1:0] SHIFT_LSR = 2'b00;
    localparam logic [1:0] SHIFT_ASR = 2'b01;
    localparam logic [1:0] SHIFT_ROR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    function automatic int unsigned min_amount(input int unsigned amt, input int unsigned width);
        return (amt < width) ? amt : width;
    endfunction

endpackage

// File: rtl/serial_right_shifter_shift_step.sv
// Combinational one-bit right step: the vacated MSB takes the supplied fill bit.
module shift_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    assign result = {fill, data[WIDTH-1:1]};

endmodule

// File: rtl/serial_right_shifter.sv
// Multi-cycle right shifter (logical/arithmetic, one bit per clock) with start/busy/done.
// Define SERIAL_RIGHT_SHIFTER_ROTATE_EN to make mode 2'b10 rotate right instead of logical.
module serial_right_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned AMT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     value,
    input  logic [AMT_WIDTH-1:0] shift_amount,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     shifted_value
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [WIDTH-1:0] result_nx;
    logic [WIDTH-1:0] step_out;
    logic [CNT_W-1:0] count, count_nx;
    logic [CNT_W-1:0] amount;
    logic             fill_bit, fill_nx;
    logic             step_fill;
    logic             busy_nx, done_nx;

`ifdef SERIAL_RIGHT_SHIFTER_ROTATE_EN
    logic rotate, rotate_nx;
    assign step_fill = rotate ? shreg[0] : fill_bit;
`else
    assign step_fill = fill_bit;
`endif

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data   (shreg),
        .fill   (step_fill),
        .result (step_out)
    );

    // The result register is loaded on the same edge that enters DONE, so it is
    // already valid while done is high and then holds until the next accept.
    always_comb begin
        state_nx  = state;
        shreg_nx  = shreg;
        count_nx  = count;
        fill_nx   = fill_bit;
        result_nx = shifted_value;
        busy_nx   = busy;
        done_nx   = 1'b0;
        amount    = '0;
`ifdef SERIAL_RIGHT_SHIFTER_ROTATE_EN
        rotate_nx = rotate;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    amount  = CNT_W'(min_amount(32'(shift_amount), WIDTH));
                    fill_nx = (mode == SHIFT_ASR) ? value[WIDTH-1] : 1'b0;
`ifdef SERIAL_RIGHT_SHIFTER_ROTATE_EN
                    rotate_nx = (mode == SHIFT_ROR);
                    if (mode == SHIFT_ROR) begin
                        amount = CNT_W'(32'(shift_amount) % WIDTH);
                    end
`endif
                    shreg_nx = value;
                    count_nx = amount;
                    busy_nx  = 1'b1;
                    if (amount == '0) begin
                        state_nx  = ST_DONE;
                        done_nx   = 1'b1;
                        result_nx = value;
                    end else begin
                        state_nx = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                shreg_nx = step_out;
                count_nx = count - 1'b1;
                if (count == CNT_W'(1)) begin
                    state_nx  = ST_DONE;
                    done_nx   = 1'b1;
                    result_nx = step_out;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = ST_IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            shreg         <= '0;
            count         <= '0;
            fill_bit      <= 1'b0;
            shifted_value <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef SERIAL_RIGHT_SHIFTER_ROTATE_EN
            rotate        <= 1'b0;
`endif
        end else begin
            state         <= state_nx;
            shreg         <= shreg_nx;
            count         <= count_nx;
            fill_bit      <= fill_nx;
            shifted_value <= result_nx;
            busy          <= busy_nx;
            done          <= done_nx;
`ifdef SERIAL_RIGHT_SHIFTER_ROTATE_EN
            rotate        <= rotate_nx;
`endif
        end
    end

endmodule

// File: tb/tb_serial_right_shifter.sv
// Randomized self-checking bench for serial_right_shifter against an arithmetic reference model.
// Honours SERIAL_RIGHT_SHIFTER_ROTATE_EN the same way as the design.
module tb_serial_right_shifter;

    localparam logic [1:0] M_LSR = 2'b00;
    localparam logic [1:0] M_ASR = 2'b01;
    localparam logic [1:0] M_ROR = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] value;
    logic [7:0]  shift_amount;
    logic        busy;
    logic        done;
    logic [15:0] shifted_value;

    int checks = 0;
    int errors = 0;

    serial_right_shifter #(.WIDTH(16), .AMT_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .mode          (mode),
        .value         (value),
        .shift_amount  (shift_amount),
        .busy          (busy),
        .done          (done),
        .shifted_value (shifted_value)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_result(input logic [15:0] v, input logic [7:0] amt,
                                                 input logic [1:0] m);
        int unsigned a;
        int unsigned r;
        a = amt;
        r = a % 16;
`ifdef SERIAL_RIGHT_SHIFTER_ROTATE_EN
        if (m == M_ROR) return (r == 0) ? v : ((v >> r) | (v << (16 - r)));
`endif
        if (m == M_ASR) return (a >= 16) ? {16{v[15]}} : 16'($signed(v) >>> a);
        return (a >= 16) ? 16'h0000 : (v >> a);
    endfunction

    function automatic int model_latency(input logic [7:0] amt, input logic [1:0] m);
        int unsigned a;
        a = amt;
`ifdef SERIAL_RIGHT_SHIFTER_ROTATE_EN
        if (m == M_ROR) return int'(a % 16) + 1;
`endif
        return ((a >= 16) ? 16 : int'(a)) + 1;
    endfunction

    // Drives one request and observes 'window' cycles after the accepting edge.
    // lat is the sample index (1 = first negedge after accept) where done first appears.
    task automatic do_op(input logic [15:0] v, input logic [7:0] amt, input logic [1:0] m,
                         input int hold, input logic [15:0] v2, input int window,
                         output logic [15:0] res, output int lat, output int ndone,
                         output int nbusy, output logic [15:0] res_end);
        res = '0; lat = -1; ndone = 0; nbusy = 0;
        @(negedge clk);
        start = 1'b1; value = v; shift_amount = amt; mode = m;
        @(posedge clk);
        for (int k = 1; k <= window; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat < 0) begin lat = k; res = shifted_value; end
            end
            if (busy) nbusy++;
            if (k >= hold) start = 1'b0;
            else value = v2;
        end
        res_end = shifted_value;
        for (int k = 0; k < 40 && (busy || done); k++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mode = M_LSR; value = '0; shift_amount = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (shifted_value !== 16'h0000) begin
            errors++; $display("FAIL reset_value got %h want 0000", shifted_value); end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] vv [6] = '{16'hF0F0, 16'h8001, 16'h8001, 16'h8001, 16'h1234, 16'h7FFF};
        logic [7:0]  aa [6] = '{8'd4, 8'd3, 8'd20, 8'd20, 8'd0, 8'd16};
        logic [1:0]  mm [6] = '{M_LSR, M_ASR, M_ASR, M_LSR, M_LSR, M_ASR};
        logic [15:0] ee [6] = '{16'h0F0F, 16'hF000, 16'hFFFF, 16'h0000, 16'h1234, 16'h0000};
        int          ll [6] = '{5, 4, 17, 17, 1, 17};
        logic [15:0] res, res_end;
        int lat, nd, nb;
        for (int i = 0; i < 6; i++) begin
            do_op(vv[i], aa[i], mm[i], 1, 16'h0000, 20, res, lat, nd, nb, res_end);
            checks++; if (res !== ee[i]) begin errors++;
                $display("FAIL directed_result[%0d] got %h want %h", i, res, ee[i]); end
            checks++; if (lat != ll[i]) begin errors++;
                $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, ll[i]); end
            checks++; if (nb != ll[i]) begin errors++;
                $display("FAIL directed_busy_cycles[%0d] got %0d want %0d", i, nb, ll[i]); end
            checks++; if (nd != 1) begin errors++;
                $display("FAIL directed_done_count[%0d] got %0d want 1", i, nd); end
        end
    endtask

    task automatic test_handshake();
        logic [15:0] res, res_end;
        int lat, nd, nb;
        do_op(16'hA5C3, 8'd5, M_LSR, 10, 16'h1111, 10, res, lat, nd, nb, res_end);
        checks++; if (nd != 1) begin errors++; $display("FAIL handshake_done_count got %0d want 1", nd); end
        checks++; if (lat != 6) begin errors++; $display("FAIL handshake_latency got %0d want 6", lat); end
        checks++; if (res !== 16'h052E) begin errors++;
            $display("FAIL handshake_result got %h want 052e", res); end
    endtask

    task automatic test_reset_abort();
        logic [15:0] res, res_end;
        int lat, nd, nb;
        int ndone;
        do_op(16'hF0F0, 8'd4, M_LSR, 1, 16'h0000, 20, res, lat, nd, nb, res_end);
        @(negedge clk);
        start = 1'b1; value = 16'hBEEF; shift_amount = 8'd8; mode = M_ASR;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        checks++; if (shifted_value !== 16'h0000) begin errors++;
            $display("FAIL abort_value got %h want 0000", shifted_value); end
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", ndone); end
        do_op(16'hBEEF, 8'd8, M_ASR, 1, 16'h0000, 20, res, lat, nd, nb, res_end);
        checks++; if (res !== 16'hFFBE) begin errors++; $display("FAIL abort_restart got %h want ffbe", res); end
        checks++; if (lat != 9) begin errors++; $display("FAIL abort_restart_lat got %0d want 9", lat); end
    endtask

    task automatic test_rotate();
        logic [15:0] res, res_end;
        int lat, nd, nb;
`ifdef SERIAL_RIGHT_SHIFTER_ROTATE_EN
        logic [15:0] e1 = 16'h8000, e2 = 16'h8000;
        int          l2 = 2;
`else
        logic [15:0] e1 = 16'h0000, e2 = 16'h0000;
        int          l2 = 17;
`endif
        do_op(16'h0001, 8'd1, M_ROR, 1, 16'h0000, 20, res, lat, nd, nb, res_end);
        checks++; if (res !== e1) begin errors++; $display("FAIL rotate_amt1 got %h want %h", res, e1); end
        checks++; if (lat != 2) begin errors++; $display("FAIL rotate_amt1_lat got %0d want 2", lat); end
        do_op(16'h0001, 8'd17, M_ROR, 1, 16'h0000, 20, res, lat, nd, nb, res_end);
        checks++; if (res !== e2) begin errors++; $display("FAIL rotate_amt17 got %h want %h", res, e2); end
        checks++; if (lat != l2) begin errors++; $display("FAIL rotate_amt17_lat got %0d want %0d", lat, l2); end
    endtask

    task automatic test_random();
        logic [15:0] v, res, res_end, exp;
        logic [7:0]  a;
        logic [1:0]  m;
        int lat, nd, nb, el;
        for (int i = 0; i < 60; i++) begin
            v = 16'($urandom);
            a = (i % 3 == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
            m = 2'($urandom_range(0, 3));
            exp = model_result(v, a, m);
            el  = model_latency(a, m);
            do_op(v, a, m, 1, 16'h0000, 20, res, lat, nd, nb, res_end);
            checks++; if (res !== exp) begin errors++;
                $display("FAIL rand_result v=%h a=%0d m=%0d got %h want %h", v, a, m, res, exp); end
            checks++; if (lat != el) begin errors++;
                $display("FAIL rand_latency a=%0d m=%0d got %0d want %0d", a, m, lat, el); end
            checks++; if (nb != el || nd != 1) begin errors++;
                $display("FAIL rand_busy_done busy=%0d done=%0d want %0d/1", nb, nd, el); end
            checks++; if (res_end !== exp) begin errors++;
                $display("FAIL rand_hold got %h want %h", res_end, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_reset_abort();
        test_rotate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
